// File: rtl/lcd_timing_pkg.sv
// Shared types for the LCD timing generator: phase enums, the shadowed
// timing bundle and the phase-sequencing helpers.
package lcd_timing_pkg;

   // Shadow fields are stored at this fixed width. HW, VW and LEDW of the
   // generator must not exceed it.
   localparam int CFG_W = 16;

   typedef enum logic [2:0] {HIDLE, HSW, HBP, HACT, HFP} h_state_t;
   typedef enum logic [2:0] {VIDLE, VSW, VBP, VACT, VFP} v_state_t;
   typedef enum logic [1:0] {LE_IDLE, LE_DLY, LE_OUT} le_state_t;

   // Timing set that stays frozen for one whole frame.
   typedef struct packed {
      logic [CFG_W-1:0] hsw;
      logic [CFG_W-1:0] hbp;
      logic [CFG_W-1:0] ppl;
      logic [CFG_W-1:0] hfp;
      logic [CFG_W-1:0] vsw;
      logic [CFG_W-1:0] vbp;
      logic [CFG_W-1:0] lpp;
      logic [CFG_W-1:0] vfp;
      logic [CFG_W-1:0] led;
      logic             ihs;
      logic             ivs;
      logic             ioe;
      logic             lee;
   } lcd_timing_cfg_t;

   // Horizontal phase that follows the given one; the front porch wraps to sync.
   function automatic h_state_t next_h(input h_state_t s);
      case (s)
         HSW:     return HBP;
         HBP:     return HACT;
         HACT:    return HFP;
         default: return HSW;
      endcase
   endfunction

   // Vertical phase that follows the given one; the front porch wraps to sync.
   function automatic v_state_t next_v(input v_state_t s);
      case (s)
         VSW:     return VBP;
         VBP:     return VACT;
         VACT:    return VFP;
         default: return VSW;
      endcase
   endfunction

endpackage

// File: rtl/lcd_le_pulse.sv
// Line-end strobe: waits 'led' clocks after a trigger, then drives le high
// for LE_PULSE clocks. Triggers while busy are ignored.
module lcd_le_pulse
   import lcd_timing_pkg::*;
#(
   parameter int LEDW     = 7,
   parameter int LE_PULSE = 2
) (
   input  logic             pixel_clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             trig,
   input  logic [CFG_W-1:0] led,
   output logic             le
);

   localparam int PW = (LE_PULSE > 1) ? $clog2(LE_PULSE) : 1;

   le_state_t       state, state_next;
   logic [LEDW-1:0] dcnt, dcnt_next;
   logic [PW-1:0]   pcnt, pcnt_next;

   // Next-state logic for the delay/pulse sequencer.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_next = state;
      dcnt_next  = dcnt;
      pcnt_next  = pcnt;
      if (clr) begin
         state_next = LE_IDLE;
         dcnt_next  = '0;
         pcnt_next  = '0;
      end else begin
         case (state)
            LE_IDLE: begin
               if (trig) begin
                  if (led == '0) begin
                     state_next = LE_OUT;
                     pcnt_next  = '0;
                  end else begin
                     state_next = LE_DLY;
                     dcnt_next  = LEDW'(1);
                  end
               end
            end
            LE_DLY: begin
               if (CFG_W'(dcnt) == led) begin
                  state_next = LE_OUT;
                  pcnt_next  = '0;
               end else begin
                  dcnt_next = dcnt + 1'b1;
               end
            end
            LE_OUT: begin
               if (pcnt == PW'(LE_PULSE - 1)) begin
                  state_next = LE_IDLE;
               end else begin
                  pcnt_next = pcnt + 1'b1;
               end
            end
            default: state_next = LE_IDLE;
         endcase
      end
   end

   // Sequencer state and the registered strobe output.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LE_IDLE;
         dcnt  <= '0;
         pcnt  <= '0;
         le    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state <= state_next;
         dcnt  <= dcnt_next;
         pcnt  <= pcnt_next;
         le    <= (state_next == LE_OUT);
      end
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: horizontal/vertical phase FSMs, frame-boundary
// shadowing of the timing set, polarity-adjusted registered sync outputs,
// pixel coordinates and line/frame markers.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int HW       = 12,
   parameter int VW       = 12,
   parameter int CW       = 10,
   parameter int LEDW     = 7,
   parameter int LE_PULSE = 2
) (
   input  logic            pixel_clk,
   input  logic            rst_n,
   input  logic            lcd_en,
   input  logic [HW-1:0]   cfg_hsw,
   input  logic [HW-1:0]   cfg_hbp,
   input  logic [HW-1:0]   cfg_ppl,
   input  logic [HW-1:0]   cfg_hfp,
   input  logic [VW-1:0]   cfg_vsw,
   input  logic [VW-1:0]   cfg_vbp,
   input  logic [VW-1:0]   cfg_lpp,
   input  logic [VW-1:0]   cfg_vfp,
   input  logic            cfg_ihs,
   input  logic            cfg_ivs,
   input  logic            cfg_ioe,
   input  logic            cfg_lee,
   input  logic [LEDW-1:0] cfg_led,
   output logic            LCDLP,
   output logic            LCDFP,
   output logic            LCDENA,
   output logic            LCDLE,
   output logic [CW-1:0]   x_count,
   output logic [CW-1:0]   y_count,
   output logic            pixel_disp_on,
   output logic            line_start,
   output logic            frame_start
);

   h_state_t        h_state, h_next;
   v_state_t        v_state, v_next;
   logic [HW-1:0]   h_cnt, h_cnt_next;
   logic [VW-1:0]   v_cnt, v_cnt_next;
   lcd_timing_cfg_t sh, sh_next, cfg_in;

   logic [CFG_W-1:0] h_lim, v_lim;
   logic             h_last, v_last;
   logic             start_up, line_end, frame_end;

   logic            de_cur, de_next;
   logic            lp_next, fp_next, ena_next;
   logic [CW-1:0]   x_next, y_next;

   // Phase-length comparisons and the line/frame boundary strobes. The
   // counters are compared zero-extended, so an all-ones limit still matches
   // before the counter could wrap.
   always_comb begin
      cfg_in = '{hsw: CFG_W'(cfg_hsw), hbp: CFG_W'(cfg_hbp),
                 ppl: CFG_W'(cfg_ppl), hfp: CFG_W'(cfg_hfp),
                 vsw: CFG_W'(cfg_vsw), vbp: CFG_W'(cfg_vbp),
                 lpp: CFG_W'(cfg_lpp), vfp: CFG_W'(cfg_vfp),
                 led: CFG_W'(cfg_led),
                 ihs: cfg_ihs, ivs: cfg_ivs, ioe: cfg_ioe, lee: cfg_lee};
      case (h_state)
         HSW:     h_lim = sh.hsw;
         HBP:     h_lim = sh.hbp;
         HACT:    h_lim = sh.ppl;
         HFP:     h_lim = sh.hfp;
         default: h_lim = '0;
      endcase
      case (v_state)
         VSW:     v_lim = sh.vsw;
         VBP:     v_lim = sh.vbp;
         VACT:    v_lim = sh.lpp;
         VFP:     v_lim = sh.vfp;
         default: v_lim = '0;
      endcase
      h_last    = (CFG_W'(h_cnt) == h_lim);
      v_last    = (CFG_W'(v_cnt) == v_lim);
      start_up  = lcd_en && (h_state == HIDLE);
      line_end  = lcd_en && (h_state == HFP) && h_last;
      frame_end = line_end && (v_state == VFP) && v_last;
   end

   // Next state of both FSMs, the shadow set and every registered output.
   always_comb begin
      h_next     = h_state;
      h_cnt_next = h_cnt;
      v_next     = v_state;
      v_cnt_next = v_cnt;
      sh_next    = sh;
      y_next     = y_count;

      if (start_up || frame_end) begin
         sh_next = cfg_in;
      end

      if (!lcd_en) begin
         h_next     = HIDLE;
         h_cnt_next = '0;
         v_next     = VIDLE;
         v_cnt_next = '0;
      end else if (h_state == HIDLE) begin
         h_next     = HSW;
         h_cnt_next = '0;
         v_next     = VSW;
         v_cnt_next = '0;
      end else begin
         if (h_last) begin
            h_next     = next_h(h_state);
            h_cnt_next = '0;
         end else begin
            h_cnt_next = h_cnt + 1'b1;
         end
         if (line_end) begin
            if (v_last) begin
               v_next     = next_v(v_state);
               v_cnt_next = '0;
            end else begin
               v_cnt_next = v_cnt + 1'b1;
            end
         end
      end

      de_cur  = (h_state == HACT) && (v_state == VACT);
      de_next = (h_next == HACT) && (v_next == VACT);

      // Polarity comes from the shadow being loaded this edge, so the first
      // cycle of a new frame already shows the new polarity.
      lp_next  = lcd_en && ((h_next == HSW) ^ sh_next.ihs);
      fp_next  = lcd_en && ((v_next == VSW) ^ sh_next.ivs);
      ena_next = lcd_en && (de_next ^ sh_next.ioe);

      x_next = (de_cur && de_next) ? x_count + 1'b1 : '0;

      if (!lcd_en) begin
         y_next = '0;
      end else if (line_end && (v_state == VACT)) begin
         y_next = (v_next == VFP) ? '0 : y_count + 1'b1;
      end
   end

   // State, counters, shadow set and outputs, all updated on the same edge.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_state       <= HIDLE;
         v_state       <= VIDLE;
         h_cnt         <= '0;
         v_cnt         <= '0;
         sh            <= '0;
         LCDLP         <= 1'b0;
         LCDFP         <= 1'b0;
         LCDENA        <= 1'b0;
         x_count       <= '0;
         y_count       <= '0;
         pixel_disp_on <= 1'b0;
         line_start    <= 1'b0;
         frame_start   <= 1'b0;
      end else begin
         h_state       <= h_next;
         v_state       <= v_next;
         h_cnt         <= h_cnt_next;
         v_cnt         <= v_cnt_next;
         sh            <= sh_next;
         LCDLP         <= lp_next;
         LCDFP         <= fp_next;
         LCDENA        <= ena_next;
         x_count       <= x_next;
         y_count       <= y_next;
         pixel_disp_on <= lcd_en && de_next;
         line_start    <= start_up || line_end;
         frame_start   <= start_up || frame_end;
      end
   end

   lcd_le_pulse #(
      .LEDW     (LEDW),
      .LE_PULSE (LE_PULSE)
   ) u_le (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .clr       (!lcd_en),
      .trig      (line_end && sh.lee),
      .led       (sh.led),
      .le        (LCDLE)
   );

endmodule
